mem_req_arbiter: RTL and testbench

//  Arbitrates icache and dcache block-fill requests onto the single memory port, one LOAD per cycle.

---
 rtl/mem_req_arbiter_if.sv | 34 +++
 rtl/mem_req_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Request, memory-port and response signals shared between the caches, the arbiter and memory.
// The master modport is the arbiter side; the slave modport is the cache/memory environment.
interface mem_req_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             icache_req_valid;
  logic [31:0]      icache_req_addr;
  logic             icache_req_accepted;
  logic             dcache_req_valid;
  logic [31:0]      dcache_req_addr;
  logic             dcache_req_accepted;
  logic [1:0]       proc2mem_command;
  logic [31:0]      proc2mem_addr;
  logic [TAG_W-1:0] mem2proc_transaction_tag;
  logic [TAG_W-1:0] mem2proc_data_tag;
  logic             icache_resp_valid;
  logic             dcache_resp_valid;

  modport master (
    input  icache_req_valid, icache_req_addr, dcache_req_valid, dcache_req_addr,
    input  mem2proc_transaction_tag, mem2proc_data_tag,
    output icache_req_accepted, dcache_req_accepted,
    output proc2mem_command, proc2mem_addr,
    output icache_resp_valid, dcache_resp_valid
  );

  modport slave (
    output icache_req_valid, icache_req_addr, dcache_req_valid, dcache_req_addr,
    output mem2proc_transaction_tag, mem2proc_data_tag,
    input  icache_req_accepted, dcache_req_accepted,
    input  proc2mem_command, proc2mem_addr,
    input  icache_resp_valid, dcache_resp_valid
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// icache/dcache block-fill arbiter onto one memory port, with per-tag owner tracking for responses.
// Optional MEM_ARB_STATS_EN adds grant/reject counters.
module mem_req_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  mem_req_arbiter_if.master bus,
  output logic [TAG_W-1:0] inflight_count,
  output logic             stray_tag_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]      icache_grant_cnt,
  output logic [31:0]      dcache_grant_cnt,
  output logic [31:0]      reject_cnt
`endif
);

  localparam int               ENTRIES    = 2 ** TAG_W;
  localparam int               SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TAG_W-1:0] MAX_TAG    = TAG_W'(NUM_TAGS);
  localparam logic [1:0]       CMD_NONE   = 2'd0;
  localparam logic [1:0]       CMD_LOAD   = 2'd1;

  logic [ENTRIES-1:0] inflight_q, inflight_d;
  logic [ENTRIES-1:0] owner_q, owner_d;
  logic [SC_W-1:0]    starve_q, starve_d;
  logic               stray_q, stray_d;
  logic [TAG_W-1:0]   count_q, count_d;

  logic icache_win, dcache_win, tag_ok, icache_acc, dcache_acc;
  logic data_hit;

  always_comb begin
    icache_win = bus.icache_req_valid && (!bus.dcache_req_valid || starve_q == STARVE_MAX);
    dcache_win = bus.dcache_req_valid && !icache_win;
    tag_ok     = bus.mem2proc_transaction_tag != '0;
    icache_acc = icache_win && tag_ok;
    dcache_acc = dcache_win && tag_ok;

    bus.icache_req_accepted = icache_acc;
    bus.dcache_req_accepted = dcache_acc;
    bus.proc2mem_command    = CMD_NONE;
    bus.proc2mem_addr       = '0;
    if (icache_win) begin
      bus.proc2mem_command = CMD_LOAD;
      bus.proc2mem_addr    = {bus.icache_req_addr[31:3], 3'b000};
    end else if (dcache_win) begin
      bus.proc2mem_command = CMD_LOAD;
      bus.proc2mem_addr    = {bus.dcache_req_addr[31:3], 3'b000};
    end

    // Routing uses the pre-edge owner, so a same-cycle reissue of the tag cannot steal the response.
    data_hit              = (bus.mem2proc_data_tag != '0) && inflight_q[bus.mem2proc_data_tag];
    bus.icache_resp_valid = data_hit && !owner_q[bus.mem2proc_data_tag];
    bus.dcache_resp_valid = data_hit &&  owner_q[bus.mem2proc_data_tag];
  end

  always_comb begin
    inflight_d = inflight_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    stray_d    = stray_q;
    count_d    = '0;

    if (data_hit) begin
      inflight_d[bus.mem2proc_data_tag] = 1'b0;
    end else if (bus.mem2proc_data_tag != '0) begin
      stray_d = 1'b1;
    end

    // Applied after the clear so a same-cycle issue of the returning tag leaves it in flight.
    if ((icache_acc || dcache_acc) && bus.mem2proc_transaction_tag <= MAX_TAG) begin
      inflight_d[bus.mem2proc_transaction_tag] = 1'b1;
      owner_d[bus.mem2proc_transaction_tag]    = dcache_acc;
    end

    if (!bus.icache_req_valid || icache_acc) begin
      starve_d = '0;
    end else if (dcache_acc && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    for (int i = 1; i < ENTRIES; i++) begin
      count_d = count_d + TAG_W'(inflight_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= '0;
      owner_q    <= '0;
      starve_q   <= '0;
      stray_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      stray_q    <= stray_d;
      count_q    <= count_d;
    end
  end

  assign inflight_count = count_q;
  assign stray_tag_err  = stray_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icache_grant_cnt_q, icache_grant_cnt_d;
  logic [31:0] dcache_grant_cnt_q, dcache_grant_cnt_d;
  logic [31:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    icache_grant_cnt_d = icache_grant_cnt_q + {31'd0, icache_acc};
    dcache_grant_cnt_d = dcache_grant_cnt_q + {31'd0, dcache_acc};
    reject_cnt_d       = reject_cnt_q + {31'd0, (icache_win || dcache_win) && !tag_ok};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      icache_grant_cnt_q <= '0;
      dcache_grant_cnt_q <= '0;
      reject_cnt_q       <= '0;
    end else begin
      icache_grant_cnt_q <= icache_grant_cnt_d;
      dcache_grant_cnt_q <= dcache_grant_cnt_d;
      reject_cnt_q       <= reject_cnt_d;
    end
  end

  assign icache_grant_cnt = icache_grant_cnt_q;
  assign dcache_grant_cnt = dcache_grant_cnt_q;
  assign reject_cnt       = reject_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed and randomized bench for mem_req_arbiter against a tag-table reference model.
module tb_mem_req_arbiter;
  localparam int NUM_TAGS     = 15;
  localparam int TAG_W        = 4;
  localparam int STARVE_LIMIT = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [TAG_W-1:0] inflight_count;
  logic             stray_tag_err;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icache_grant_cnt, dcache_grant_cnt, reject_cnt;
`endif

  mem_req_arbiter_if #(.TAG_W(TAG_W)) bus ();

  mem_req_arbiter #(
    .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master),
    .inflight_count(inflight_count),
    .stray_tag_err(stray_tag_err)
`ifdef MEM_ARB_STATS_EN
    ,
    .icache_grant_cnt(icache_grant_cnt),
    .dcache_grant_cnt(dcache_grant_cnt),
    .reject_cnt(reject_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: which tags are out, who owns them, how long icache has waited.
  bit m_busy [NUM_TAGS+1];
  bit m_dc   [NUM_TAGS+1];
  int m_wait = 0;
  bit m_stray = 0;
  int unsigned m_ig = 0, m_dg = 0, m_rj = 0;

  function automatic int model_count();
    int n = 0;
    for (int t = 1; t <= NUM_TAGS; t++) n += int'(m_busy[t]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit iv, input logic [31:0] ia,
                      input bit dv, input logic [31:0] da,
                      input int mt, input int dt);
    int winner;
    logic [31:0] exp_addr;
    bit acc, exp_ir, exp_dr;
    @(negedge clock);
    reset = rst;
    bus.icache_req_valid = iv;
    bus.icache_req_addr  = ia;
    bus.dcache_req_valid = dv;
    bus.dcache_req_addr  = da;
    bus.mem2proc_transaction_tag = TAG_W'(mt);
    bus.mem2proc_data_tag        = TAG_W'(dt);
    #1;
    // 0 = nobody, 1 = icache, 2 = dcache
    if (iv && dv) winner = (m_wait >= STARVE_LIMIT) ? 1 : 2;
    else if (iv)  winner = 1;
    else if (dv)  winner = 2;
    else          winner = 0;
    exp_addr = (winner == 1) ? ia : (winner == 2) ? da : 32'd0;
    exp_addr = exp_addr - (exp_addr % 8);
    acc = (winner != 0) && (mt != 0);
    exp_ir = (dt != 0) && m_busy[dt] && !m_dc[dt];
    exp_dr = (dt != 0) && m_busy[dt] &&  m_dc[dt];

    chk("icache_accepted", {31'd0, bus.icache_req_accepted}, {31'd0, acc && winner == 1});
    chk("dcache_accepted", {31'd0, bus.dcache_req_accepted}, {31'd0, acc && winner == 2});
    chk("command", {30'd0, bus.proc2mem_command}, (winner != 0) ? 32'd1 : 32'd0);
    chk("addr", bus.proc2mem_addr, exp_addr);
    chk("icache_resp", {31'd0, bus.icache_resp_valid}, {31'd0, exp_ir});
    chk("dcache_resp", {31'd0, bus.dcache_resp_valid}, {31'd0, exp_dr});
    chk("inflight_count", {28'd0, inflight_count}, 32'(model_count()));
    chk("stray_tag_err", {31'd0, stray_tag_err}, {31'd0, m_stray});
`ifdef MEM_ARB_STATS_EN
    chk("icache_grant_cnt", icache_grant_cnt, m_ig);
    chk("dcache_grant_cnt", dcache_grant_cnt, m_dg);
    chk("reject_cnt", reject_cnt, m_rj);
`endif

    if (rst) begin
      for (int t = 0; t <= NUM_TAGS; t++) begin
        m_busy[t] = 0;
        m_dc[t] = 0;
      end
      m_wait = 0; m_stray = 0; m_ig = 0; m_dg = 0; m_rj = 0;
    end else begin
      if (dt != 0) begin
        if (m_busy[dt]) m_busy[dt] = 0;
        else m_stray = 1;
      end
      if (acc) begin
        m_busy[mt] = 1;
        m_dc[mt] = (winner == 2);
        if (winner == 1) m_ig++; else m_dg++;
      end else if (winner != 0) begin
        m_rj++;
      end
      if (!iv || (acc && winner == 1)) m_wait = 0;
      else if (acc && winner == 2 && m_wait < STARVE_LIMIT) m_wait++;
    end
  endtask

  task automatic idle(input int dt);
    step(0, 0, 32'd0, 0, 32'd0, 0, dt);
  endtask

  initial begin
    int mt, dt, pick;
    bus.icache_req_valid = 0; bus.icache_req_addr = '0;
    bus.dcache_req_valid = 0; bus.dcache_req_addr = '0;
    bus.mem2proc_transaction_tag = '0; bus.mem2proc_data_tag = '0;
    for (int t = 0; t <= NUM_TAGS; t++) begin
      m_busy[t] = 0;
      m_dc[t] = 0;
    end

    step(1, 0, 32'd0, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 0, 32'd0, 0, 0);
    idle(0);

    // Dcache-only fill and its return
    step(0, 0, 32'd0, 1, 32'h0000_1234, 3, 0);
    idle(0);
    idle(3);
    idle(0);

    // Memory rejects twice, then accepts dcache
    step(0, 1, 32'h0000_4000, 1, 32'h0000_8008, 0, 0);
    step(0, 1, 32'h0000_4000, 1, 32'h0000_8008, 0, 0);
    step(0, 1, 32'h0000_4000, 1, 32'h0000_8008, 5, 0);
    idle(5);

    // Starvation: dcache four times, icache on the fifth
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0200, 1, 0);
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0208, 2, 0);
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0210, 4, 0);
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0218, 6, 0);
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0220, 8, 0);
    step(0, 1, 32'h0000_0100, 1, 32'h0000_0228, 10, 0);
    idle(1); idle(2); idle(4); idle(6); idle(8); idle(10);

    // Same tag returned to icache while reissued to dcache
    step(0, 1, 32'h0000_0700, 0, 32'd0, 7, 0);
    step(0, 0, 32'd0, 1, 32'h0000_0777, 7, 7);
    idle(0);
    idle(7);

    // Stray return
    idle(9);
    idle(0);
    idle(0);

    // Reset with three tags outstanding, then a late return
    step(0, 0, 32'd0, 1, 32'h0000_1000, 11, 0);
    step(0, 1, 32'h0000_2000, 0, 32'd0, 12, 0);
    step(0, 0, 32'd0, 1, 32'h0000_3000, 13, 0);
    step(1, 0, 32'd0, 0, 32'd0, 0, 0);
    idle(0);
    idle(12);
    idle(0);
    step(1, 0, 32'd0, 0, 32'd0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      mt = 0;
      if ($urandom_range(0, 9) != 0) begin
        for (int k = 0; k < 8 && mt == 0; k++) begin
          pick = int'($urandom_range(1, NUM_TAGS));
          if (!m_busy[pick]) mt = pick;
        end
      end
      dt = 0;
      pick = int'($urandom_range(0, 19));
      if (pick < 8) begin
        for (int k = 0; k < 8 && dt == 0; k++) begin
          pick = int'($urandom_range(1, NUM_TAGS));
          if (m_busy[pick]) dt = pick;
        end
      end else if (pick == 8) begin
        dt = int'($urandom_range(1, NUM_TAGS));
      end
      step(n % 97 == 96, $urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom, mt, dt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
